// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: registered RV32I(+M) decode stage with valid/ready handshake,
// flush, and a programmable hold-off before M-op bundles are presented.
module ctrl_unit_pipe #(
    parameter int ENABLE_M   = 1,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic        i_instr_vld,
    output logic        o_instr_rdy,
    input  logic        i_flush,
    input  logic        i_ctrl_rdy,
    output logic        o_ctrl_vld,
    output logic [31:0] o_instr,
    output logic        o_insn_vld,
    output logic        o_rd_wren,
    output logic        o_imme_sel,
    output logic        o_br_unsigned,
    output logic        o_is_branch,
    output logic        o_is_jump,
    output logic        o_mem_rden,
    output logic        o_mem_wren,
    output logic [3:0]  o_alu_op,
    output logic        o_md_sel,
    output logic [2:0]  o_md_op,
    output logic [2:0]  o_ld_rewrite,
    output logic [1:0]  o_st_rewrite,
    output logic [1:0]  o_wb_sel
);
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
    typedef struct packed {
        logic       insn_vld;
        logic       rd_wren;
        logic       imme_sel;
        logic       br_unsigned;
        logic       is_branch;
        logic       is_jump;
        logic       mem_rden;
        logic       mem_wren;
        logic [3:0] alu_op;
        logic       md_sel;
        logic [2:0] md_op;
        logic [2:0] ld_rewrite;
        logic [1:0] st_rewrite;
        logic [1:0] wb_sel;
    } bundle_t;
    localparam bundle_t NOP = '{insn_vld: 1'b0, rd_wren: 1'b0, imme_sel: 1'b0, br_unsigned: 1'b0,
                                is_branch: 1'b0, is_jump: 1'b0, mem_rden: 1'b0, mem_wren: 1'b0,
                                alu_op: 4'd11, md_sel: 1'b0, md_op: 3'd0, ld_rewrite: 3'd5,
                                st_rewrite: 2'd3, wb_sel: 2'd3};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LATENCY > 0 ? MD_LATENCY - 1 : 0);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      instr_q;
    bundle_t          bnd_q, dec;
    logic             acc;
    wire  [6:0]       op = i_instr[6:0];
    wire  [2:0]       f3 = i_instr[14:12];
    wire  [6:0]       f7 = i_instr[31:25];
    // funct3 -> ALU op shared by OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
        case (f)
            3'd0:    alu_of = alt ? 4'd1 : 4'd0;
            3'd1:    alu_of = 4'd7;
            3'd2:    alu_of = 4'd2;
            3'd3:    alu_of = 4'd3;
            3'd4:    alu_of = 4'd4;
            3'd5:    alu_of = alt ? 4'd9 : 4'd8;
            3'd6:    alu_of = 4'd5;
            default: alu_of = 4'd6;
        endcase
    endfunction
    always_comb begin
        dec = NOP;
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000001) begin
                    if (ENABLE_M != 0) begin
                        dec.insn_vld = 1'b1;
                        dec.rd_wren  = 1'b1;
                        dec.md_sel   = 1'b1;
                        dec.md_op    = f3;
                        dec.wb_sel   = 2'd1;
                    end
                end else if (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    dec.insn_vld = 1'b1;
                    dec.rd_wren  = 1'b1;
                    dec.alu_op   = alu_of(f3, f7[5]);
                    dec.wb_sel   = 2'd1;
                end
            end
            7'b0010011: begin
                if (f3 == 3'd1 ? f7 == 7'b0 : f3 == 3'd5 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1) begin
                    dec.insn_vld = 1'b1;
                    dec.rd_wren  = 1'b1;
                    dec.imme_sel = 1'b1;
                    dec.alu_op   = alu_of(f3, f3 == 3'd5 && f7[5]);
                    dec.wb_sel   = 2'd1;
                end
            end
            7'b0000011: begin
                if (f3 != 3'd3 && f3 < 3'd6) begin
                    dec.insn_vld   = 1'b1;
                    dec.rd_wren    = 1'b1;
                    dec.imme_sel   = 1'b1;
                    dec.mem_rden   = 1'b1;
                    dec.alu_op     = 4'd0;
                    dec.ld_rewrite = f3 == 3'd4 ? 3'd3 : f3 == 3'd5 ? 3'd4 : f3;
                    dec.wb_sel     = 2'd0;
                end
            end
            7'b0100011: begin
                if (f3 < 3'd3) begin
                    dec.insn_vld   = 1'b1;
                    dec.imme_sel   = 1'b1;
                    dec.mem_wren   = 1'b1;
                    dec.alu_op     = 4'd0;
                    dec.st_rewrite = f3[1:0];
                end
            end
            7'b1100011: begin
                if (f3 != 3'd2 && f3 != 3'd3) begin
                    dec.insn_vld    = 1'b1;
                    dec.is_branch   = 1'b1;
                    dec.br_unsigned = f3[2] & f3[1];
                    dec.alu_op      = 4'd0;
                end
            end
            7'b1101111, 7'b1100111: begin
                if (op[3] || f3 == 3'd0) begin
                    dec.insn_vld = 1'b1;
                    dec.rd_wren  = 1'b1;
                    dec.imme_sel = 1'b1;
                    dec.is_jump  = 1'b1;
                    dec.alu_op   = 4'd0;
                    dec.wb_sel   = 2'd2;
                end
            end
            7'b0110111, 7'b0010111: begin
                dec.insn_vld = 1'b1;
                dec.rd_wren  = 1'b1;
                dec.imme_sel = 1'b1;
                dec.alu_op   = op[5] ? 4'd10 : 4'd0;
                dec.wb_sel   = 2'd1;
            end
            default: dec = NOP;
        endcase
    end
    assign o_instr_rdy = !i_flush && (state_q == IDLE || (state_q == OUT && i_ctrl_rdy));
    assign acc         = i_instr_vld && o_instr_rdy;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (acc) begin
            state_d = (dec.md_sel && MD_LATENCY > 0) ? WAIT : OUT;
            cnt_d   = (dec.md_sel && MD_LATENCY > 0) ? CNT_INIT : '0;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == '0 ? OUT : WAIT;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        end else if (state_q == OUT && i_ctrl_rdy) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            bnd_q   <= NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc) begin
                instr_q <= i_instr;
                bnd_q   <= dec;
            end
        end
    end
    assign o_ctrl_vld    = state_q == OUT;
    assign o_instr       = instr_q;
    assign o_insn_vld    = bnd_q.insn_vld;
    assign o_rd_wren     = bnd_q.rd_wren;
    assign o_imme_sel    = bnd_q.imme_sel;
    assign o_br_unsigned = bnd_q.br_unsigned;
    assign o_is_branch   = bnd_q.is_branch;
    assign o_is_jump     = bnd_q.is_jump;
    assign o_mem_rden    = bnd_q.mem_rden;
    assign o_mem_wren    = bnd_q.mem_wren;
    assign o_alu_op      = bnd_q.alu_op;
    assign o_md_sel      = bnd_q.md_sel;
    assign o_md_op       = bnd_q.md_op;
    assign o_ld_rewrite  = bnd_q.ld_rewrite;
    assign o_st_rewrite  = bnd_q.st_rewrite;
    assign o_wb_sel      = bnd_q.wb_sel;
endmodule
